// File: rtl/vec_exec_pkg.sv
// Shared types and sizing for the vector execute unit.
// Opcodes, FSM states and pass/shift sizing helpers.
package vec_exec_pkg;

    localparam int REGI_SIZE  = 16;
    localparam int VECT_SIZE  = 8;
    localparam int ELEM_SIZE  = 8;
    localparam int VECT_LANES = 3;
    localparam int OP_BITS    = 3;

    localparam int PASSES     = (VECT_SIZE + VECT_LANES - 1) / VECT_LANES;
    localparam int SHAMT_BITS = $clog2(ELEM_SIZE);

    typedef enum logic [2:0] {
        VADD  = 3'd0,
        VSUB  = 3'd1,
        VXOR  = 3'd2,
        VAND  = 3'd3,
        VOR   = 3'd4,
        VSHL  = 3'd5,
        VSHR  = 3'd6,
        VROTL = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int passes_f(input int vs, input int vl);
        return (vs + vl - 1) / vl;
    endfunction

endpackage

// File: rtl/vec_exec_unit_if.sv
// Request/result bundle between the operand register and the vector unit.
// master drives the request, slave returns status and result.
interface vec_exec_unit_if #(
    parameter int REGI_SIZE = 16,
    parameter int VECT_SIZE = 8,
    parameter int ELEM_SIZE = 8,
    parameter int OP_BITS   = 3
);
    logic                           start_i;
    logic [OP_BITS-1:0]             op_i;
    logic [REGI_SIZE-1:0]           intOper1_i;
    logic [ELEM_SIZE*VECT_SIZE-1:0] vecOper1_i;
    logic [ELEM_SIZE*VECT_SIZE-1:0] vecOper2_i;
    logic                           busy_o;
    logic                           done_o;
    logic [ELEM_SIZE*VECT_SIZE-1:0] vecResult_o;

    modport master (
        output start_i, op_i, intOper1_i, vecOper1_i, vecOper2_i,
        input  busy_o, done_o, vecResult_o
    );

    modport slave (
        input  start_i, op_i, intOper1_i, vecOper1_i, vecOper2_i,
        output busy_o, done_o, vecResult_o
    );
endinterface

// File: rtl/vec_lane_alu.sv
// Single-element combinational ALU for one vector lane.
// Unsigned arithmetic, results wrap at the element width.
module vec_lane_alu
    import vec_exec_pkg::*;
#(
    parameter int EW = 8,
    parameter int SW = 3
) (
    input  logic [EW-1:0] a_i,
    input  logic [EW-1:0] b_i,
    input  logic [SW-1:0] s_i,
    input  op_e           op_i,
    output logic [EW-1:0] y_o
);

    logic [2*EW-1:0] rot;

    // Doubled operand shifted left: upper half is the rotate result.
    always_comb begin
        rot = {a_i, a_i} << s_i;
    end

    // Per-element operation select.
    always_comb begin
        y_o = '0;
        unique case (op_i)
            VADD:  y_o = a_i + b_i;
            VSUB:  y_o = a_i - b_i;
            VXOR:  y_o = a_i ^ b_i;
            VAND:  y_o = a_i & b_i;
            VOR:   y_o = a_i | b_i;
            VSHL:  y_o = a_i << s_i;
            VSHR:  y_o = a_i >> s_i;
            VROTL: y_o = rot[2*EW-1:EW];
        endcase
    end

endmodule

// File: rtl/vec_exec_unit.sv
// Multi-pass vector ALU: VECT_LANES elements per cycle.
// Operands captured on start; result held until the next start.
module vec_exec_unit #(
    parameter int REGI_SIZE  = vec_exec_pkg::REGI_SIZE,
    parameter int VECT_SIZE  = vec_exec_pkg::VECT_SIZE,
    parameter int ELEM_SIZE  = vec_exec_pkg::ELEM_SIZE,
    parameter int VECT_LANES = vec_exec_pkg::VECT_LANES,
    parameter int OP_BITS    = vec_exec_pkg::OP_BITS
) (
    input logic           clk_i,
    input logic           rst_ni,
    vec_exec_unit_if.slave bus
);
    import vec_exec_pkg::*;

    localparam int NPASS = passes_f(VECT_SIZE, VECT_LANES);
    localparam int SW    = $clog2(ELEM_SIZE);
    localparam int IW    = $clog2(NPASS + 1);
    localparam int VW    = ELEM_SIZE * VECT_SIZE;

    state_e         state_q, state_d;
    op_e            op_q, op_d;
    logic [SW-1:0]  sh_q, sh_d;
    logic [VW-1:0]  v1_q, v1_d;
    logic [VW-1:0]  v2_q, v2_d;
    logic [VW-1:0]  res_q, res_d;
    logic [IW-1:0]  idx_q, idx_d;

    logic                  accept;
    logic                  last;
    logic [VECT_LANES-1:0] lane_en;
    int                    lane_pos [VECT_LANES];
    logic [ELEM_SIZE-1:0]  lane_a   [VECT_LANES];
    logic [ELEM_SIZE-1:0]  lane_b   [VECT_LANES];
    logic [ELEM_SIZE-1:0]  lane_y   [VECT_LANES];
    logic                  unused_hi;

    assign unused_hi = ^bus.intOper1_i[REGI_SIZE-1:SW];

    // Map each lane to its element for the current pass; gate lanes past the end.
    always_comb begin
        for (int l = 0; l < VECT_LANES; l++) begin
            lane_en[l]  = (int'(idx_q) * VECT_LANES + l) < VECT_SIZE;
            lane_pos[l] = lane_en[l] ? int'(idx_q) * VECT_LANES + l : 0;
            lane_a[l]   = v1_q[lane_pos[l]*ELEM_SIZE +: ELEM_SIZE];
            lane_b[l]   = v2_q[lane_pos[l]*ELEM_SIZE +: ELEM_SIZE];
        end
    end

    for (genvar g = 0; g < VECT_LANES; g++) begin : g_lane
        vec_lane_alu #(.EW(ELEM_SIZE), .SW(SW)) u_alu (
            .a_i (lane_a[g]),
            .b_i (lane_b[g]),
            .s_i (sh_q),
            .op_i(op_q),
            .y_o (lane_y[g])
        );
    end

    assign accept = bus.start_i && (state_q == IDLE || state_q == DONE);
    assign last   = (idx_q == IW'(NPASS - 1));

    // FSM next state, pass write-back and operand capture.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        sh_d    = sh_q;
        v1_d    = v1_q;
        v2_d    = v2_q;
        res_d   = res_q;
        idx_d   = idx_q;
        unique case (1'b1)
            (state_q == RUN): begin
                for (int l = 0; l < VECT_LANES; l++) begin
                    if (lane_en[l]) begin
                        res_d[lane_pos[l]*ELEM_SIZE +: ELEM_SIZE] = lane_y[l];
                    end
                end
                idx_d = idx_q + 1'b1;
                if (last) state_d = DONE;
            end
            (state_q == DONE): state_d = IDLE;
            default: ;
        endcase
        if (accept) begin
            op_d    = op_e'(bus.op_i[2:0]);
            sh_d    = bus.intOper1_i[SW-1:0];
            v1_d    = bus.vecOper1_i;
            v2_d    = bus.vecOper2_i;
            res_d   = '0;
            idx_d   = '0;
            state_d = RUN;
        end
    end

    // State and datapath registers, async clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            op_q    <= VADD;
            sh_q    <= '0;
            v1_q    <= '0;
            v2_q    <= '0;
            res_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sh_q    <= sh_d;
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            res_q   <= res_d;
            idx_q   <= idx_d;
        end
    end

    assign bus.busy_o      = (state_q == RUN);
    assign bus.done_o      = (state_q == DONE);
    assign bus.vecResult_o = res_q;

endmodule

// File: tb/tb_vec_exec_unit.sv
// Scoreboard bench for vec_exec_unit.
// Directed scenarios plus one random pass per opcode.
module tb_vec_exec_unit;
    import vec_exec_pkg::*;

    localparam int NP = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vec_exec_unit_if bus ();

    vec_exec_unit dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    function automatic logic [7:0] ref_elem(input logic [2:0] op,
                                            input logic [7:0] a,
                                            input logic [7:0] b,
                                            input int s);
        logic [7:0] r;
        r = 8'h00;
        case (op)
            VADD:  r = 8'(a + b);
            VSUB:  r = 8'(a - b);
            VXOR:  r = a ^ b;
            VAND:  r = a & b;
            VOR:   r = a | b;
            VSHL:  r = a << s;
            VSHR:  r = a >> s;
            default: begin
                r = a;
                for (int k = 0; k < s; k++) r = {r[6:0], r[7]};
            end
        endcase
        return r;
    endfunction

    function automatic logic [63:0] ref_vec(input logic [2:0] op,
                                            input logic [63:0] a,
                                            input logic [63:0] b,
                                            input logic [15:0] i);
        logic [63:0] r;
        int s;
        s = int'(i[2:0]);
        r = '0;
        for (int k = 0; k < 8; k++)
            r[k*8 +: 8] = ref_elem(op, a[k*8 +: 8], b[k*8 +: 8], s);
        return r;
    endfunction

    task automatic issue(input logic [2:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [15:0] i,
                         input logic [63:0] e);
        bus.start_i    = 1'b1;
        bus.op_i       = op;
        bus.vecOper1_i = a;
        bus.vecOper2_i = b;
        bus.intOper1_i = i;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
    endtask

    task automatic wait_done(input string name, input int already);
        int n;
        logic [63:0] e;
        n = already;
        while (bus.done_o !== 1'b1 && n < 20) begin
            checks++;
            if (bus.busy_o !== 1'b1) begin
                errors++;
                $display("FAIL %s_busy got %b want 1 at pass %0d", name, bus.busy_o, n);
            end
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (bus.done_o !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout got done=%b want 1", name, bus.done_o);
        end
        checks++;
        if (n !== NP) begin
            errors++;
            $display("FAIL %s_latency got %0d want %0d", name, n, NP);
        end
        checks++;
        if (bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_in_done got %b want 0", name, bus.busy_o);
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s_scoreboard got empty want entry", name);
        end else begin
            e = exp_q.pop_front();
            if (bus.vecResult_o !== e) begin
                errors++;
                $display("FAIL %s_result got %h want %h", name, bus.vecResult_o, e);
            end
        end
    endtask

    task automatic idle_after(input string name);
        @(posedge clk);
        #1;
        checks++;
        if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle got done=%b busy=%b want 0 0", name, bus.done_o, bus.busy_o);
        end
    endtask

    task automatic test_reset();
        bus.start_i    = 1'b0;
        bus.op_i       = 3'd0;
        bus.intOper1_i = '0;
        bus.vecOper1_i = '0;
        bus.vecOper2_i = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.vecResult_o !== 64'h0) begin
            errors++;
            $display("FAIL reset got busy=%b done=%b res=%h want 0 0 0",
                     bus.busy_o, bus.done_o, bus.vecResult_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle_after("reset_release");
    endtask

    task automatic test_vadd();
        issue(VADD, {8{8'hF0}}, {8{8'h20}}, 16'h0000, 64'h1010101010101010);
        wait_done("vadd", 0);
        idle_after("vadd");
    endtask

    task automatic test_vrotl();
        issue(VROTL, 64'h8001FF0102030481, 64'h0, 16'h0009, 64'h0102FF0204060803);
        wait_done("vrotl", 0);
        idle_after("vrotl");
    endtask

    task automatic test_vsub_partial();
        issue(VSUB, 64'h0, 64'h0706050403020100, 16'h0000, 64'hF9FAFBFCFDFEFF00);
        checks++;
        if (bus.vecResult_o !== 64'h0) begin
            errors++;
            $display("FAIL vsub_clear got %h want %h", bus.vecResult_o, 64'h0);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.vecResult_o !== 64'h0000000000FEFF00) begin
            errors++;
            $display("FAIL vsub_pass0 got %h want %h", bus.vecResult_o, 64'h0000000000FEFF00);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.vecResult_o !== 64'h0000FBFCFDFEFF00) begin
            errors++;
            $display("FAIL vsub_pass1 got %h want %h", bus.vecResult_o, 64'h0000FBFCFDFEFF00);
        end
        wait_done("vsub", 2);
        idle_after("vsub");
        checks++;
        if (bus.vecResult_o !== 64'hF9FAFBFCFDFEFF00) begin
            errors++;
            $display("FAIL vsub_hold got %h want %h", bus.vecResult_o, 64'hF9FAFBFCFDFEFF00);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] a1, b1, a2, b2;
        time t1;
        a1 = 64'h0123456789ABCDEF;
        b1 = 64'hFF00FF00F0F00F0F;
        a2 = 64'h1122334455667788;
        b2 = 64'h8000400020001000;
        issue(VXOR, a1, b1, 16'h0, ref_vec(VXOR, a1, b1, 16'h0));
        wait_done("b2b_first", 0);
        t1 = $time;
        issue(VOR, a2, b2, 16'h0, ref_vec(VOR, a2, b2, 16'h0));
        checks++;
        if (bus.busy_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_no_bubble got busy=%b want 1", bus.busy_o);
        end
        bus.start_i    = 1'b1;
        bus.op_i       = VADD;
        bus.vecOper1_i = ~a2;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        wait_done("b2b_second", 1);
        checks++;
        if ($time - t1 != 40) begin
            errors++;
            $display("FAIL b2b_spacing got %0t want 40", $time - t1);
        end
        idle_after("b2b");
    endtask

    task automatic test_async_reset();
        issue(VAND, 64'hFFFFFFFFFFFFFFFF, 64'h5A5A5A5A5A5A5A5A, 16'h0, 64'h5A5A5A5A5A5A5A5A);
        @(posedge clk);
        #1;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.vecResult_o !== 64'h0) begin
            errors++;
            $display("FAIL async_reset got busy=%b done=%b res=%h want 0 0 0",
                     bus.busy_o, bus.done_o, bus.vecResult_o);
        end
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) begin
                errors++;
                $display("FAIL async_post_%0d got done=%b busy=%b want 0 0",
                         c, bus.done_o, bus.busy_o);
            end
        end
    endtask

    task automatic test_input_change();
        logic [63:0] a, b;
        a = 64'h0F1E2D3C4B5A6978;
        b = 64'h1111111111111111;
        issue(VSHL, a, b, 16'hFFF3, ref_vec(VSHL, a, b, 16'hFFF3));
        bus.vecOper1_i = ~a;
        bus.vecOper2_i = ~b;
        bus.intOper1_i = 16'h0001;
        bus.op_i       = VSUB;
        wait_done("input_change", 0);
        idle_after("input_change");
    endtask

    task automatic test_all_ops();
        logic [63:0] a, b;
        logic [15:0] i;
        for (int op = 0; op < 8; op++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            i = 16'($urandom);
            issue(3'(op), a, b, i, ref_vec(3'(op), a, b, i));
            wait_done($sformatf("op%0d", op), 0);
            idle_after($sformatf("op%0d", op));
        end
    endtask

    initial begin
        test_reset();
        test_vadd();
        test_vrotl();
        test_vsub_partial();
        test_back_to_back();
        test_async_reset();
        test_input_change();
        test_all_ops();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
